branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch resolution and prediction unit for the pipelined RV32I core. It replaces the flag-driven branch/jump resolver. It adds an ENTRIES-deep direct-mapped branch target buffer (BTB) with 2-bit saturating counters, looked up in IF. Branches and jumps are resolved in EX from raw operands; the outcome is checked against the prediction carried down the pipe, and a flush plus redirect PC is raised on a mismatch. Saturating performance counters record resolved and mispredicted control transfers.

## Interface
- XLEN, 32, datapath/PC width
- ENTRIES, 16, BTB depth; power of two, ≥2
- CNT_W, 32, performance counter width
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IF_PC  in  XLEN  fetch-stage PC (lookup)
- PRED_TAKEN  out  1  IF prediction: redirect fetch
- PRED_TARGET  out  XLEN  IF predicted target
- EX_VALID  in  1  EX stage holds a valid (non-bubble) instruction
- EX_PC  in  XLEN  PC of EX instruction
- BRANCH_SIGNAL  in  1  EX instruction is a conditional branch
- JUMP_SIGNAL  in  1  EX instruction is JAL/JALR
- FUNC_3  in  3  branch condition
- RS1_DATA, RS2_DATA  in  XLEN  compare operands
- BRANCH_IMM  in  XLEN  sign-extended branch offset
- JUMP_TARGET  in  XLEN  ALU-computed jump target
- EX_PRED_TAKEN  in  1  prediction made for this instruction in IF
- EX_PRED_TARGET  in  XLEN  target predicted in IF
- MISPREDICT  out  1  flush IF/ID and redirect fetch
- REDIRECT_PC  out  XLEN  correct next PC when MISPREDICT=1
- BR_COUNT  out  CNT_W  resolved branches+jumps
- MISP_COUNT  out  CNT_W  mispredictions

## Operation
- Index = PC[log2(ENTRIES)+1:2]; tag = PC[XLEN-1:log2(ENTRIES)+2]. Each entry holds valid, tag, target, jump bit, and a 2-bit counter.
- Lookup (combinational): hit = valid & tag match.
  - PRED_TAKEN = hit & (jump | ctr[1]).
  - PRED_TARGET = entry target.
  - On no hit, PRED_TARGET is don't-care.
- Condition by FUNC_3:
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010/011 never taken.
- Resolution: resolve = EX_VALID & (BRANCH_SIGNAL | JUMP_SIGNAL).
  - taken = JUMP_SIGNAL | (BRANCH_SIGNAL & cond).
  - target = JUMP_SIGNAL ? JUMP_TARGET : EX_PC+BRANCH_IMM, modulo 2^XLEN.
- MISPREDICT, when resolve is high:
  - EX_PRED_TAKEN≠taken, or
  - taken & EX_PRED_TARGET≠target.
- MISPREDICT, when EX_VALID & !resolve & EX_PRED_TAKEN (aliasing hit on a non-branch): also asserted.
- MISPREDICT is 0 otherwise.
- REDIRECT_PC = taken ? target : EX_PC+4.
- Table update on resolve, at the clock edge:
  - Tag hit: counter saturating +1 if taken, -1 if not taken (saturate at 11 and 00). Target is written only when taken.
  - Tag miss/invalid: allocate the entry, overwriting it. Counter = 10 if taken, 01 if not. Target = target if taken, else EX_PC+4.
  - Jumps: jump bit=1, counter=11, target=JUMP_TARGET. Branches: jump bit=0.
- Aliasing mispredict on a non-branch: clear the valid bit of the entry at EX_PC's index.
- Perf counters (saturate at all-ones, never wrap):
  - BR_COUNT +1 per resolve.
  - MISP_COUNT +1 per MISPREDICT.

## Timing
- Lookup, resolution, MISPREDICT and REDIRECT_PC are combinational, with zero latency.
- Table and counter writes are visible from the cycle after the update edge.
- Same-cycle lookup and update at the same index: the lookup returns the pre-update contents (no bypass).
- RESET high at an edge:
  - All valid bits, jump bits and perf counters are cleared.
  - Counters are set to 01 and targets to 0.
  - Reset overrides any pending update.
- While RESET is high, PRED_TAKEN=0 and MISPREDICT=0, whatever the other inputs.
- Reset asserted mid-stream discards the in-flight update. The cycle after reset deasserts, every lookup misses.
- EX_VALID=0: no update and no MISPREDICT, even if the other inputs are asserted.

## Test plan
- Reset, then IF_PC=0x100 → PRED_TAKEN=0, BR_COUNT=0, MISP_COUNT=0.
- BEQ at 0x100, RS1=RS2=5, IMM=0x40, EX_PRED_TAKEN=0:
  - Same cycle: MISPREDICT=1, REDIRECT_PC=0x140.
  - Next cycle: IF_PC=0x100 gives PRED_TAKEN=1, PRED_TARGET=0x140.
- Same BEQ resolved not-taken (RS1=1, RS2=2) three times:
  - Counter goes 10→01→00→00.
  - MISP_COUNT +1 on the first resolution only; BR_COUNT +3.
- BLT RS1=0xFFFFFFFF, RS2=1 → taken. BLTU with the same operands → not taken.
  - FUNC_3=010 → not taken.
- JALR at 0x200 with JUMP_TARGET=0x300 and predicted target 0x280 → MISPREDICT=1, REDIRECT_PC=0x300.
  - The entry is updated, so the next lookup gives 0x300 with PRED_TAKEN=1.
- Aliasing and reset cases:
  - ALU op at 0x140 (ENTRIES=16 aliases index with 0x100) with EX_PRED_TAKEN=1 → MISPREDICT=1, REDIRECT_PC=0x144, entry invalidated.
  - RESET during a resolve → no update, and the next lookup misses.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-side signal bundle for branch_predict_unit.
// The master side (core pipeline) drives lookup and resolution inputs.
// The slave side (predictor) returns predictions, flush/redirect and perf counters.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  IF_PC;
  logic             PRED_TAKEN;
  logic [XLEN-1:0]  PRED_TARGET;
  logic             EX_VALID;
  logic [XLEN-1:0]  EX_PC;
  logic             BRANCH_SIGNAL;
  logic             JUMP_SIGNAL;
  logic [2:0]       FUNC_3;
  logic [XLEN-1:0]  RS1_DATA;
  logic [XLEN-1:0]  RS2_DATA;
  logic [XLEN-1:0]  BRANCH_IMM;
  logic [XLEN-1:0]  JUMP_TARGET;
  logic             EX_PRED_TAKEN;
  logic [XLEN-1:0]  EX_PRED_TARGET;
  logic             MISPREDICT;
  logic [XLEN-1:0]  REDIRECT_PC;
  logic [CNT_W-1:0] BR_COUNT;
  logic [CNT_W-1:0] MISP_COUNT;

  modport master (
    output IF_PC, EX_VALID, EX_PC, BRANCH_SIGNAL, JUMP_SIGNAL, FUNC_3,
           RS1_DATA, RS2_DATA, BRANCH_IMM, JUMP_TARGET, EX_PRED_TAKEN, EX_PRED_TARGET,
    input  PRED_TAKEN, PRED_TARGET, MISPREDICT, REDIRECT_PC, BR_COUNT, MISP_COUNT
  );

  modport slave (
    input  IF_PC, EX_VALID, EX_PC, BRANCH_SIGNAL, JUMP_SIGNAL, FUNC_3,
           RS1_DATA, RS2_DATA, BRANCH_IMM, JUMP_TARGET, EX_PRED_TAKEN, EX_PRED_TARGET,
    output PRED_TAKEN, PRED_TARGET, MISPREDICT, REDIRECT_PC, BR_COUNT, MISP_COUNT
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit: direct-mapped BTB with 2-bit
// saturating counters looked up in IF, branch/jump resolution in EX,
// mispredict flush/redirect, and saturating perf counters.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input logic                  CLK,
  input logic                  RESET,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic             jump_q   [ENTRIES];
  logic             jump_d   [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [CNT_W-1:0] br_cnt_q,   br_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             cond, resolve, taken, misp;
  logic [XLEN-1:0]  br_target, target, pc_plus4;

  assign if_idx = bus.IF_PC[IDX_W+1:2];
  assign if_tag = bus.IF_PC[XLEN-1:IDX_W+2];
  assign ex_idx = bus.EX_PC[IDX_W+1:2];
  assign ex_tag = bus.EX_PC[XLEN-1:IDX_W+2];

  // IF lookup: reads the registered table, so a same-cycle update is not bypassed
  always_comb begin
    if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    bus.PRED_TAKEN  = !RESET && if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
    bus.PRED_TARGET = target_q[if_idx];
  end

  // EX resolution: branch condition, actual outcome/target and mispredict detection
  always_comb begin
    cond = 1'b0;
    case (bus.FUNC_3)
      3'b000:  cond = (bus.RS1_DATA == bus.RS2_DATA);
      3'b001:  cond = (bus.RS1_DATA != bus.RS2_DATA);
      3'b100:  cond = ($signed(bus.RS1_DATA) <  $signed(bus.RS2_DATA));
      3'b101:  cond = ($signed(bus.RS1_DATA) >= $signed(bus.RS2_DATA));
      3'b110:  cond = (bus.RS1_DATA <  bus.RS2_DATA);
      3'b111:  cond = (bus.RS1_DATA >= bus.RS2_DATA);
      default: cond = 1'b0;
    endcase
    resolve   = bus.EX_VALID && (bus.BRANCH_SIGNAL || bus.JUMP_SIGNAL);
    taken     = bus.JUMP_SIGNAL || (bus.BRANCH_SIGNAL && cond);
    br_target = bus.EX_PC + bus.BRANCH_IMM;
    target    = bus.JUMP_SIGNAL ? bus.JUMP_TARGET : br_target;
    pc_plus4  = bus.EX_PC + XLEN'(4);
    misp      = 1'b0;
    if (!RESET && bus.EX_VALID) begin
      if (resolve) begin
        misp = (bus.EX_PRED_TAKEN != taken) ||
               (taken && (bus.EX_PRED_TARGET != target));
      end else begin
        // A taken prediction on a non-control instruction is an aliasing hit
        misp = bus.EX_PRED_TAKEN;
      end
    end
    bus.MISPREDICT  = misp;
    bus.REDIRECT_PC = taken ? target : pc_plus4;
  end

  // Next-state for BTB entries and perf counters
  always_comb begin
    valid_d    = valid_q;
    jump_d     = jump_q;
    tag_d      = tag_q;
    target_d   = target_q;
    ctr_d      = ctr_q;
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    if (resolve) begin
      valid_d[ex_idx] = 1'b1;
      tag_d[ex_idx]   = ex_tag;
      jump_d[ex_idx]  = bus.JUMP_SIGNAL;
      if (bus.JUMP_SIGNAL) begin
        ctr_d[ex_idx]    = 2'b11;
        target_d[ex_idx] = bus.JUMP_TARGET;
      end else if (ex_hit) begin
        if (taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
          target_d[ex_idx] = br_target;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
        end
      end else begin
        ctr_d[ex_idx]    = taken ? 2'b10 : 2'b01;
        target_d[ex_idx] = taken ? br_target : pc_plus4;
      end
    end else if (bus.EX_VALID && bus.EX_PRED_TAKEN) begin
      valid_d[ex_idx] = 1'b0;
    end

    if (resolve && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (misp && (misp_cnt_q != '1))  misp_cnt_d = misp_cnt_q + CNT_W'(1);
  end

  // State registers; reset wins over any pending update
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        jump_q[i]   <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      jump_q     <= jump_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign bus.BR_COUNT   = br_cnt_q;
  assign bus.MISP_COUNT = misp_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios with
// literal expectations, then randomized traffic checked every cycle
// against a behavioural BTB/perf-counter model.
module tb_branch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 8;
  localparam int CNTMAX  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit [31:0] tgt;
    bit        j;
    int        s;
  } ent_t;

  ent_t m[ENTRIES];
  int   m_br   = 0;
  int   m_misp = 0;
  bit   m_live = 0;

  function automatic int ix(bit [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit mhit(bit [31:0] pc);
    return m[ix(pc)].v && ((m[ix(pc)].pc >> 6) == (pc >> 6));
  endfunction

  function automatic bit mpred(bit [31:0] pc);
    return mhit(pc) && (m[ix(pc)].j || m[ix(pc)].s >= 2);
  endfunction

  function automatic bit cond_of(int f3, bit [31:0] a, bit [31:0] b);
    case (f3)
      0: return a == b;
      1: return a != b;
      4: return $signed(a) <  $signed(b);
      5: return $signed(a) >= $signed(b);
      6: return a < b;
      7: return a >= b;
      default: return 0;
    endcase
  endfunction

  // Outcome of the instruction currently presented to EX
  task automatic m_outcome(output bit res, output bit tk, output bit mp,
                           output bit [31:0] tgt, output bit [31:0] redir);
    bit [31:0] pc;
    pc    = bus.EX_PC;
    res   = bus.EX_VALID && (bus.BRANCH_SIGNAL || bus.JUMP_SIGNAL);
    tk    = bus.JUMP_SIGNAL || (bus.BRANCH_SIGNAL && cond_of(int'(bus.FUNC_3), bus.RS1_DATA, bus.RS2_DATA));
    tgt   = bus.JUMP_SIGNAL ? bus.JUMP_TARGET : pc + bus.BRANCH_IMM;
    redir = tk ? tgt : pc + 32'd4;
    if (rst || !bus.EX_VALID) mp = 0;
    else if (res) mp = (bus.EX_PRED_TAKEN != tk) || (tk && bus.EX_PRED_TARGET != tgt);
    else mp = bus.EX_PRED_TAKEN;
  endtask

  // Model state advance on each rising edge
  always @(posedge clk) begin
    bit res, tk, mp;
    bit [31:0] tgt, redir;
    int i;
    if (rst) begin
      foreach (m[k]) m[k] = '{v: 0, pc: 0, tgt: 0, j: 0, s: 1};
      m_br = 0; m_misp = 0; m_live = 1;
    end else if (m_live) begin
      m_outcome(res, tk, mp, tgt, redir);
      i = ix(bus.EX_PC);
      if (res) begin
        if (bus.JUMP_SIGNAL) begin
          m[i] = '{v: 1, pc: bus.EX_PC, tgt: bus.JUMP_TARGET, j: 1, s: 3};
        end else if (mhit(bus.EX_PC)) begin
          m[i].j = 0;
          if (tk) begin
            m[i].s   = (m[i].s == 3) ? 3 : m[i].s + 1;
            m[i].tgt = tgt;
          end else begin
            m[i].s = (m[i].s == 0) ? 0 : m[i].s - 1;
          end
        end else begin
          m[i] = '{v: 1, pc: bus.EX_PC, tgt: (tk ? tgt : bus.EX_PC + 32'd4), j: 0, s: (tk ? 2 : 1)};
        end
        if (m_br < CNTMAX) m_br++;
      end else if (bus.EX_VALID && bus.EX_PRED_TAKEN) begin
        m[i].v = 0;
      end
      if (mp && m_misp < CNTMAX) m_misp++;
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    bit res, tk, mp;
    bit [31:0] tgt, redir;
    if (m_live) begin
      m_outcome(res, tk, mp, tgt, redir);
      chk("m_pred_taken", bus.PRED_TAKEN, !rst && mpred(bus.IF_PC));
      if (!rst && mhit(bus.IF_PC)) chk("m_pred_target", bus.PRED_TARGET, m[ix(bus.IF_PC)].tgt);
      chk("m_mispredict", bus.MISPREDICT, mp);
      if (mp) chk("m_redirect", bus.REDIRECT_PC, redir);
      chk("m_br_count", bus.BR_COUNT, m_br);
      chk("m_misp_count", bus.MISP_COUNT, m_misp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.EX_VALID = 0; bus.BRANCH_SIGNAL = 0; bus.JUMP_SIGNAL = 0;
    bus.FUNC_3 = 0; bus.RS1_DATA = 0; bus.RS2_DATA = 0; bus.BRANCH_IMM = 0;
    bus.JUMP_TARGET = 0; bus.EX_PRED_TAKEN = 0; bus.EX_PRED_TARGET = 0;
    bus.EX_PC = 0;
  endtask

  task automatic branch(input bit [31:0] pc, input int f3, input bit [31:0] a, input bit [31:0] b,
                        input bit [31:0] imm, input bit pt, input bit [31:0] ptgt);
    idle();
    bus.EX_VALID = 1; bus.BRANCH_SIGNAL = 1; bus.EX_PC = pc; bus.FUNC_3 = 3'(f3);
    bus.RS1_DATA = a; bus.RS2_DATA = b; bus.BRANCH_IMM = imm;
    bus.EX_PRED_TAKEN = pt; bus.EX_PRED_TARGET = ptgt;
  endtask

  task automatic jump(input bit [31:0] pc, input bit [31:0] jt, input bit pt, input bit [31:0] ptgt);
    idle();
    bus.EX_VALID = 1; bus.JUMP_SIGNAL = 1; bus.EX_PC = pc; bus.JUMP_TARGET = jt;
    bus.EX_PRED_TAKEN = pt; bus.EX_PRED_TARGET = ptgt;
  endtask

  function automatic bit [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.IF_PC = 0;
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    bus.IF_PC = 32'h100; #3;
    chk("rst_pred_taken", bus.PRED_TAKEN, 0);
    chk("rst_br_count", bus.BR_COUNT, 0);
    chk("rst_misp_count", bus.MISP_COUNT, 0);

    // BEQ taken, predicted not-taken
    branch(32'h100, 0, 5, 5, 32'h40, 0, 0); #3;
    chk("beq_misp", bus.MISPREDICT, 1);
    chk("beq_redirect", bus.REDIRECT_PC, 32'h140);
    tick(); idle(); #3;
    chk("beq_lookup_taken", bus.PRED_TAKEN, 1);
    chk("beq_lookup_target", bus.PRED_TARGET, 32'h140);

    // Same BEQ not taken three times: counter 10 -> 01 -> 00 -> 00
    branch(32'h100, 0, 1, 2, 32'h40, 1, 32'h140); #3;
    chk("nt1_misp", bus.MISPREDICT, 1);
    chk("nt1_redirect", bus.REDIRECT_PC, 32'h104);
    tick();
    branch(32'h100, 0, 1, 2, 32'h40, 0, 0); #3;
    chk("nt2_misp", bus.MISPREDICT, 0);
    tick();
    branch(32'h100, 0, 1, 2, 32'h40, 0, 0); #3;
    chk("nt3_misp", bus.MISPREDICT, 0);
    tick(); idle(); #3;
    chk("nt_br_count", bus.BR_COUNT, 4);
    chk("nt_misp_count", bus.MISP_COUNT, 2);
    chk("nt_lookup", bus.PRED_TAKEN, 0);
    // From saturated 00 one taken resolution only reaches 01
    branch(32'h100, 0, 7, 7, 32'h40, 0, 0);
    tick(); idle(); #3;
    chk("sat00_lookup", bus.PRED_TAKEN, 0);

    // Signed vs unsigned compare, and reserved FUNC_3
    branch(32'h184, 4, 32'hFFFF_FFFF, 1, 32'h10, 0, 0); #3;
    chk("blt_misp", bus.MISPREDICT, 1);
    chk("blt_redirect", bus.REDIRECT_PC, 32'h194);
    tick();
    branch(32'h184, 6, 32'hFFFF_FFFF, 1, 32'h10, 0, 0); #3;
    chk("bltu_misp", bus.MISPREDICT, 0);
    chk("bltu_redirect", bus.REDIRECT_PC, 32'h188);
    tick();
    branch(32'h184, 2, 3, 3, 32'h10, 0, 0); #3;
    chk("f010_redirect", bus.REDIRECT_PC, 32'h188);
    tick();

    // JALR with wrong predicted target
    jump(32'h200, 32'h300, 1, 32'h280); #3;
    chk("jalr_misp", bus.MISPREDICT, 1);
    chk("jalr_redirect", bus.REDIRECT_PC, 32'h300);
    tick(); idle(); bus.IF_PC = 32'h200; #3;
    chk("jalr_lookup_taken", bus.PRED_TAKEN, 1);
    chk("jalr_lookup_target", bus.PRED_TARGET, 32'h300);

    // Aliasing hit on a non-control instruction at 0x140 (index 0)
    idle(); bus.EX_VALID = 1; bus.EX_PC = 32'h140; bus.EX_PRED_TAKEN = 1; bus.EX_PRED_TARGET = 32'h300; #3;
    chk("alias_misp", bus.MISPREDICT, 1);
    chk("alias_redirect", bus.REDIRECT_PC, 32'h144);
    tick(); idle(); #3;
    chk("alias_invalidated", bus.PRED_TAKEN, 0);

    // Reset during a resolve
    jump(32'h208, 32'h400, 0, 0);
    tick();
    branch(32'h100, 0, 5, 5, 32'h40, 0, 0); bus.IF_PC = 32'h208; rst = 1; #3;
    chk("rst_forces_no_pred", bus.PRED_TAKEN, 0);
    chk("rst_forces_no_misp", bus.MISPREDICT, 0);
    tick(); rst = 0; idle(); bus.IF_PC = 32'h100; #3;
    chk("post_rst_miss_100", bus.PRED_TAKEN, 0);
    chk("post_rst_br", bus.BR_COUNT, 0);
    chk("post_rst_misp", bus.MISP_COUNT, 0);
    bus.IF_PC = 32'h208; #3;
    chk("post_rst_miss_208", bus.PRED_TAKEN, 0);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 2000; n++) begin
      bit [31:0] pc;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      pc = rnd_pc();
      bus.IF_PC          = rnd_pc();
      bus.EX_PC          = pc;
      bus.EX_VALID       = ($urandom_range(0, 9) != 0);
      bus.BRANCH_SIGNAL  = $urandom_range(0, 1);
      bus.JUMP_SIGNAL    = ($urandom_range(0, 3) == 0);
      bus.FUNC_3         = 3'($urandom_range(0, 7));
      bus.RS1_DATA       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.RS2_DATA       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.BRANCH_IMM     = 32'($signed(12'($urandom_range(0, 4095)) & 12'hFFC));
      bus.JUMP_TARGET    = rnd_pc();
      if ($urandom_range(0, 4) != 0) begin
        bus.EX_PRED_TAKEN  = mpred(pc);
        bus.EX_PRED_TARGET = m[ix(pc)].tgt;
      end else begin
        bus.EX_PRED_TAKEN  = $urandom_range(0, 1);
        bus.EX_PRED_TARGET = rnd_pc();
      end
    end
    @(posedge clk); #1;
    rst = 0;
    idle();
    @(posedge clk); #1;
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
